// File: rtl/fdiv_seq.sv
// Request sequencer in front of a multi-cycle FP divider: FIFO-buffered requests, one divide in flight,
// tagged results through a one-entry valid/ready register. Optional completion timeout: FDIV_SEQ_TIMEOUT_EN.
module fdiv_seq #(
    parameter int DATAW  = 32,
    parameter int TAGW   = 4,
    parameter int DEPTH  = 4,
    parameter int MAXLAT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [DATAW-1:0] req_a,
    input  logic [DATAW-1:0] req_b,
    input  logic [1:0]       req_op,
    input  logic [TAGW-1:0]  req_tag,
    output logic             div_dispatch,
    output logic [DATAW-1:0] div_a,
    output logic [DATAW-1:0] div_b,
    output logic [1:0]       div_op,
    input  logic             div_done,
    input  logic [DATAW-1:0] div_q,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [DATAW-1:0] rsp_q,
    output logic [TAGW-1:0]  rsp_tag,
    output logic             rsp_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(MAXLAT + 1);

    typedef enum logic [1:0] {
        S_FLUSH = 2'd0,
        S_IDLE  = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [DATAW-1:0] a;
        logic [DATAW-1:0] b;
        logic [1:0]       op;
        logic [TAGW-1:0]  tag;
    } entry_t;

    entry_t [DEPTH-1:0] fifo_q, fifo_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic               empty_s, full_s, push_s, pop_s;
    entry_t             head_s;

    state_t             state_q, state_d;
    logic [CW-1:0]      flush_cnt_q, flush_cnt_d;
    logic [TAGW-1:0]    cur_tag_q, cur_tag_d;
    logic [DATAW-1:0]   div_a_q, div_a_d, div_b_q, div_b_d;
    logic [1:0]         div_op_q, div_op_d;
    logic               div_dispatch_q, div_dispatch_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DATAW-1:0]   rsp_q_q, rsp_q_d;
    logic [TAGW-1:0]    rsp_tag_q, rsp_tag_d;

`ifdef FDIV_SEQ_TIMEOUT_EN
    localparam int EXPW = (DATAW == 64) ? 11 : ((DATAW == 16) ? 5 : 8);
    localparam int MANW = DATAW - 1 - EXPW;

    logic [CW-1:0]      wait_cnt_q, wait_cnt_d;
    logic               rsp_err_q, rsp_err_d;

    // Negative quiet NaN: sign set, exponent all ones, mantissa MSB set.
    function automatic logic [DATAW-1:0] neg_qnan();
        return {1'b1, {EXPW{1'b1}}, 1'b1, {(MANW-1){1'b0}}};
    endfunction
`endif

    // FIFO status and push/pointer/storage next-state; a full FIFO refuses pushes even on a same-cycle pop.
    always_comb begin
        empty_s  = (wr_ptr_q == rd_ptr_q);
        full_s   = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]);
        push_s   = req_valid && !full_s;
        head_s   = fifo_q[rd_ptr_q[AW-1:0]];
        fifo_d   = fifo_q;
        wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, push_s};
        rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, pop_s};
        if (push_s) begin
            fifo_d[wr_ptr_q[AW-1:0]] = '{a: req_a, b: req_b, op: req_op, tag: req_tag};
        end else begin
            fifo_d = fifo_q;
        end
    end

    // Sequencer next-state: flush stale divider activity, dispatch when the result slot is free, collect result.
    always_comb begin
        state_d        = state_q;
        flush_cnt_d    = flush_cnt_q;
        cur_tag_d      = cur_tag_q;
        div_a_d        = div_a_q;
        div_b_d        = div_b_q;
        div_op_d       = div_op_q;
        div_dispatch_d = 1'b0;
        rsp_q_d        = rsp_q_q;
        rsp_tag_d      = rsp_tag_q;
        pop_s          = 1'b0;
`ifdef FDIV_SEQ_TIMEOUT_EN
        wait_cnt_d     = wait_cnt_q;
        rsp_err_d      = rsp_err_q;
`endif
        if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end else begin
            rsp_valid_d = rsp_valid_q;
        end

        case (state_q)
            S_FLUSH: begin
                if (flush_cnt_q == CW'(MAXLAT - 1)) begin
                    state_d     = S_IDLE;
                    flush_cnt_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q + CW'(1);
                end
            end
            S_IDLE: begin
                if (!empty_s && (!rsp_valid_q || rsp_ready)) begin
                    div_a_d        = head_s.a;
                    div_b_d        = head_s.b;
                    div_op_d       = head_s.op;
                    div_dispatch_d = 1'b1;
                    cur_tag_d      = head_s.tag;
                    pop_s          = 1'b1;
                    state_d        = S_WAIT;
`ifdef FDIV_SEQ_TIMEOUT_EN
                    wait_cnt_d     = '0;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (div_done) begin
                    rsp_q_d     = div_q;
                    rsp_tag_d   = cur_tag_q;
                    rsp_valid_d = 1'b1;
                    state_d     = S_IDLE;
`ifdef FDIV_SEQ_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
                end else if (wait_cnt_q == CW'(MAXLAT - 1)) begin
                    // Give up on the divider and flush so a late completion is absorbed.
                    rsp_q_d     = neg_qnan();
                    rsp_tag_d   = cur_tag_q;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    flush_cnt_d = '0;
                    state_d     = S_FLUSH;
                end else begin
                    wait_cnt_d  = wait_cnt_q + CW'(1);
                end
`else
                end else begin
                    state_d = S_WAIT;
                end
`endif
            end
            default: begin
                state_d     = S_FLUSH;
                flush_cnt_d = '0;
            end
        endcase
    end

    // State registers; reset empties the FIFO and restarts the flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_q         <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            state_q        <= S_FLUSH;
            flush_cnt_q    <= '0;
            cur_tag_q      <= '0;
            div_a_q        <= '0;
            div_b_q        <= '0;
            div_op_q       <= 2'd0;
            div_dispatch_q <= 1'b0;
            rsp_valid_q    <= 1'b0;
            rsp_q_q        <= '0;
            rsp_tag_q      <= '0;
`ifdef FDIV_SEQ_TIMEOUT_EN
            wait_cnt_q     <= '0;
            rsp_err_q      <= 1'b0;
`endif
        end else begin
            fifo_q         <= fifo_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            state_q        <= state_d;
            flush_cnt_q    <= flush_cnt_d;
            cur_tag_q      <= cur_tag_d;
            div_a_q        <= div_a_d;
            div_b_q        <= div_b_d;
            div_op_q       <= div_op_d;
            div_dispatch_q <= div_dispatch_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_q_q        <= rsp_q_d;
            rsp_tag_q      <= rsp_tag_d;
`ifdef FDIV_SEQ_TIMEOUT_EN
            wait_cnt_q     <= wait_cnt_d;
            rsp_err_q      <= rsp_err_d;
`endif
        end
    end

    assign req_ready    = !full_s;
    assign div_dispatch = div_dispatch_q;
    assign div_a        = div_a_q;
    assign div_b        = div_b_q;
    assign div_op       = div_op_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_q        = rsp_q_q;
    assign rsp_tag      = rsp_tag_q;
`ifdef FDIV_SEQ_TIMEOUT_EN
    assign rsp_err      = rsp_err_q;
`else
    assign rsp_err      = 1'b0;
`endif

endmodule

// File: tb/tb_fdiv_seq.sv
// Self-checking bench for fdiv_seq: behavioural divider model plus an in-order result scoreboard.
module tb_fdiv_seq;
    localparam int DATAW  = 32;
    localparam int TAGW   = 4;
    localparam int DEPTH  = 4;
    localparam int MAXLAT = 64;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [DATAW-1:0] req_a = '0, req_b = '0;
    logic [1:0]       req_op = 2'd0;
    logic [TAGW-1:0]  req_tag = '0;
    logic             div_dispatch;
    logic [DATAW-1:0] div_a, div_b;
    logic [1:0]       div_op;
    logic             div_done;
    logic [DATAW-1:0] div_q;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [DATAW-1:0] rsp_q;
    logic [TAGW-1:0]  rsp_tag;
    logic             rsp_err;

    fdiv_seq #(.DATAW(DATAW), .TAGW(TAGW), .DEPTH(DEPTH), .MAXLAT(MAXLAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
        .div_dispatch(div_dispatch), .div_a(div_a), .div_b(div_b), .div_op(div_op),
        .div_done(div_done), .div_q(div_q),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_q(rsp_q), .rsp_tag(rsp_tag), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [DATAW-1:0] q;
        logic [TAGW-1:0]  tag;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Divider model result: any operand mix-up changes it; for a=0x40400000,b=0x3F800000,op=0 it yields a.
    function automatic logic [DATAW-1:0] model_f(logic [DATAW-1:0] a, logic [DATAW-1:0] b, logic [1:0] op);
        return a ^ {b[DATAW-2:0], b[DATAW-1]} ^ 32'h7F00_0000 ^ {30'd0, op};
    endfunction

    int  lat = 5;
    bit  hang = 1'b0;
    int  stray_req = 0, stray_seen = 0;
    int  disp_cnt = 0, disp_wide = 0, done_cyc = 0;
    bit  busy = 1'b0, prev_disp = 1'b0;
    int  mcnt = 0;
    logic [DATAW-1:0] ma = '0, mb = '0;
    logic [1:0]       mop = 2'd0;

    // Divider model: no reset, fixed latency, optional never-complete mode and injected stray completions.
    initial begin
        div_done = 1'b0;
        div_q    = '0;
        forever begin
            @(posedge clk); #1;
            div_done = 1'b0;
            if (stray_req != stray_seen) begin
                stray_seen = stray_req;
                div_done   = 1'b1;
                div_q      = 32'hDEAD_BEEF;
                done_cyc   = cyc;
            end else if (busy) begin
                mcnt = mcnt - 1;
                if (mcnt == 0) begin
                    div_done = 1'b1;
                    div_q    = model_f(ma, mb, mop);
                    busy     = 1'b0;
                    done_cyc = cyc;
                end
            end
            if (div_dispatch) begin
                if (prev_disp) disp_wide++;
                disp_cnt++;
                ma = div_a; mb = div_b; mop = div_op;
                busy = !hang;
                mcnt = lat;
            end
            prev_disp = div_dispatch;
        end
    end

    task automatic push(input logic [DATAW-1:0] a, input logic [DATAW-1:0] b, input logic [1:0] op,
                        input logic [TAGW-1:0] tag, output bit ok);
        req_a = a; req_b = b; req_op = op; req_tag = tag; req_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (req_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        if (ok) sb.push_back('{model_f(a, b, op), tag});
    endtask

    task automatic wait_rsp(input int budget, output bit got, output logic [DATAW-1:0] q,
                            output logic [TAGW-1:0] tag, output logic err, output int at);
        got = 1'b0; q = '0; tag = '0; err = 1'b0; at = 0;
        for (int i = 0; i < budget; i++) begin
            if (rsp_valid && rsp_ready) begin
                got = 1'b1; q = rsp_q; tag = rsp_tag; err = rsp_err; at = cyc;
                break;
            end
            @(posedge clk); #1;
        end
        if (got) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        bit ok, got, seen;
        logic [DATAW-1:0] q; logic [TAGW-1:0] tg; logic er; int at, d0;
        exp_t e;
        rst_n = 1'b0; rsp_ready = 1'b1;
        repeat (3) @(posedge clk); #1;
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid); else n_pass++;
        n_checks++; if (div_dispatch !== 1'b0) $display("FAIL rst_dispatch: got %b expected 0", div_dispatch); else n_pass++;
        n_checks++; if (req_ready !== 1'b1) $display("FAIL rst_req_ready: got %b expected 1", req_ready); else n_pass++;
        n_checks++; if ({rsp_q, rsp_tag, rsp_err} !== '0) $display("FAIL rst_rsp_data: got %h/%h/%b expected 0", rsp_q, rsp_tag, rsp_err); else n_pass++;
        n_checks++; if ({div_a, div_b, div_op} !== '0) $display("FAIL rst_div_ops: got %h/%h/%h expected 0", div_a, div_b, div_op); else n_pass++;
        rst_n = 1'b1;
        d0 = disp_cnt;
        push(32'h1234_5678, 32'h0F0F_0F0F, 2'd2, 4'd7, ok);
        n_checks++; if (ok !== 1'b1) $display("FAIL flush_accept: got %b expected 1", ok); else n_pass++;
        stray_req++;
        seen = 1'b0;
        repeat (MAXLAT - 6) begin
            @(posedge clk); #1;
            if (rsp_valid || div_dispatch) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) $display("FAIL flush_quiet: got activity %b expected 0", seen); else n_pass++;
        n_checks++; if (disp_cnt !== d0) $display("FAIL flush_no_dispatch: got %0d expected %0d", disp_cnt, d0); else n_pass++;
        wait_rsp(200, got, q, tg, er, at);
        n_checks++; if (got !== 1'b1) $display("FAIL flush_rsp_timeout: got %b expected 1", got); else n_pass++;
        if (got && sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++; if ({q, tg} !== {e.q, e.tag}) $display("FAIL flush_rsp: got %h/%h expected %h/%h", q, tg, e.q, e.tag); else n_pass++;
        end
    endtask

    task automatic test_single();
        bit ok, got;
        logic [DATAW-1:0] q; logic [TAGW-1:0] tg; logic er; int at, d0, w0;
        lat = 48; d0 = disp_cnt; w0 = disp_wide;
        push(32'h4040_0000, 32'h3F80_0000, 2'd0, 4'd5, ok);
        wait_rsp(300, got, q, tg, er, at);
        void'(sb.pop_front());
        n_checks++; if (got !== 1'b1) $display("FAIL single_timeout: got %b expected 1", got); else n_pass++;
        n_checks++; if (q !== 32'h4040_0000) $display("FAIL single_q: got %h expected 40400000", q); else n_pass++;
        n_checks++; if (tg !== 4'd5) $display("FAIL single_tag: got %h expected 5", tg); else n_pass++;
        n_checks++; if (er !== 1'b0) $display("FAIL single_err: got %b expected 0", er); else n_pass++;
        n_checks++; if (at !== done_cyc + 1) $display("FAIL single_latency: got cycle %0d expected %0d", at, done_cyc + 1); else n_pass++;
        n_checks++; if (disp_cnt - d0 !== 1) $display("FAIL single_dispatch_count: got %0d expected 1", disp_cnt - d0); else n_pass++;
        n_checks++; if (disp_wide !== w0) $display("FAIL single_pulse_width: got %0d wide pulses expected %0d", disp_wide, w0); else n_pass++;
    endtask

    task automatic test_fill();
        bit ok, all_ok, got;
        logic [DATAW-1:0] q; logic [TAGW-1:0] tg; logic er; int at;
        exp_t e;
        rst_n = 1'b0; @(posedge clk); #1; rst_n = 1'b1;
        sb.delete();
        lat = 5; rsp_ready = 1'b0; all_ok = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            push(32'h3F00_0000 + 32'(i * 32'h111), 32'h4000_0000 - 32'(i), 2'(i), 4'(i), ok);
            all_ok &= ok;
        end
        n_checks++; if (all_ok !== 1'b1) $display("FAIL fill_accept: got %b expected 1", all_ok); else n_pass++;
        req_a = 32'h4100_0000; req_b = 32'h4080_0000; req_op = 2'd3; req_tag = 4'd5; req_valid = 1'b1;
        n_checks++; if (req_ready !== 1'b0) $display("FAIL fill_full: got req_ready %b expected 0", req_ready); else n_pass++;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (req_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        if (ok) sb.push_back('{model_f(32'h4100_0000, 32'h4080_0000, 2'd3), 4'd5});
        n_checks++; if (ok !== 1'b1) $display("FAIL fill_fifth_accept: got %b expected 1", ok); else n_pass++;
        rsp_ready = 1'b1;
        for (int i = 1; i <= DEPTH + 1; i++) begin
            wait_rsp(200, got, q, tg, er, at);
            if (got && sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++; if ({q, tg} !== {e.q, e.tag}) $display("FAIL fill_order_%0d: got %h/%h expected %h/%h", i, q, tg, e.q, e.tag); else n_pass++;
            end else begin
                n_checks++; $display("FAIL fill_rsp_%0d: got no response expected tag %0d", i, i);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok, got, stable, seen;
        logic [DATAW-1:0] q, q0; logic [TAGW-1:0] tg, t0; logic er; int at, d0;
        exp_t e;
        rsp_ready = 1'b0; lat = 3;
        push(32'h4120_0000, 32'h4000_0000, 2'd1, 4'd9, ok);
        push(32'h4130_0000, 32'h3FC0_0000, 2'd2, 4'd10, ok);
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (rsp_valid) seen = 1'b1; else begin @(posedge clk); #1; end
        end
        n_checks++; if (seen !== 1'b1) $display("FAIL bp_rsp_timeout: got %b expected 1", seen); else n_pass++;
        q0 = rsp_q; t0 = rsp_tag; d0 = disp_cnt; stable = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (rsp_q !== q0 || rsp_tag !== t0 || rsp_valid !== 1'b1) stable = 1'b0;
        end
        n_checks++; if (stable !== 1'b1) $display("FAIL bp_hold: got stable %b expected 1", stable); else n_pass++;
        n_checks++; if (disp_cnt !== d0) $display("FAIL bp_no_dispatch: got %0d expected %0d", disp_cnt, d0); else n_pass++;
        rsp_ready = 1'b1;
        wait_rsp(5, got, q, tg, er, at);
        n_checks++; if (div_dispatch !== 1'b1) $display("FAIL bp_same_cycle_dispatch: got %b expected 1", div_dispatch); else n_pass++;
        e = sb.pop_front();
        n_checks++; if ({q, tg} !== {e.q, e.tag}) $display("FAIL bp_first: got %h/%h expected %h/%h", q, tg, e.q, e.tag); else n_pass++;
        wait_rsp(100, got, q, tg, er, at);
        e = sb.pop_front();
        n_checks++; if ({got, q, tg} !== {1'b1, e.q, e.tag}) $display("FAIL bp_second: got %b/%h/%h expected 1/%h/%h", got, q, tg, e.q, e.tag); else n_pass++;
    endtask

    task automatic test_reset_midwait();
        bit ok, seen;
        int d0;
        rsp_ready = 1'b1; lat = 30;
        push(32'h4200_0000, 32'h4100_0000, 2'd0, 4'd3, ok);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (div_dispatch) seen = 1'b1;
            @(posedge clk); #1;
        end
        push(32'h4210_0000, 32'h4110_0000, 2'd1, 4'd4, ok);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_checks++; if ({rsp_valid, div_dispatch, req_ready} !== 3'b001) $display("FAIL midwait_ctrl: got %b expected 001", {rsp_valid, div_dispatch, req_ready}); else n_pass++;
        n_checks++; if ({rsp_q, rsp_tag, div_a, div_b} !== '0) $display("FAIL midwait_data: got %h/%h/%h/%h expected 0", rsp_q, rsp_tag, div_a, div_b); else n_pass++;
        sb.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        d0 = disp_cnt; seen = 1'b0;
        repeat (MAXLAT + 20) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) $display("FAIL midwait_stale_done: got rsp_valid %b expected 0", seen); else n_pass++;
        n_checks++; if (disp_cnt !== d0) $display("FAIL midwait_discard: got %0d dispatches expected %0d", disp_cnt, d0); else n_pass++;
    endtask

    task automatic test_back_to_back();
        bit ok, got;
        logic [DATAW-1:0] q; logic [TAGW-1:0] tg; logic er; int at;
        exp_t e;
        rsp_ready = 1'b1; lat = 1;
        for (int i = 0; i < 3; i++) push(32'h4300_0000 ^ 32'(i << 4), 32'h3E00_0000 + 32'(i), 2'(i), 4'(11 + i), ok);
        for (int i = 0; i < 3; i++) begin
            wait_rsp(100, got, q, tg, er, at);
            if (got && sb.size() > 0) begin
                e = sb.pop_front();
                n_checks++; if ({q, tg, er} !== {e.q, e.tag, 1'b0}) $display("FAIL b2b_%0d: got %h/%h/%b expected %h/%h/0", i, q, tg, er, e.q, e.tag); else n_pass++;
            end else begin
                n_checks++; $display("FAIL b2b_rsp_%0d: got no response expected one", i);
            end
        end
        n_checks++; if (sb.size() !== 0) $display("FAIL sb_drain: got %0d left expected 0", sb.size()); else n_pass++;
    endtask

`ifdef FDIV_SEQ_TIMEOUT_EN
    task automatic test_timeout();
        bit ok, got, seen;
        logic [DATAW-1:0] q; logic [TAGW-1:0] tg; logic er; int at;
        rsp_ready = 1'b1; hang = 1'b1;
        push(32'h4400_0000, 32'h4000_0000, 2'd0, 4'd6, ok);
        sb.delete();
        wait_rsp(MAXLAT + 50, got, q, tg, er, at);
        n_checks++; if ({got, q, tg, er} !== {1'b1, 32'hFFC0_0000, 4'd6, 1'b1}) $display("FAIL timeout_rsp: got %b/%h/%h/%b expected 1/ffc00000/6/1", got, q, tg, er); else n_pass++;
        hang = 1'b0;
        repeat (4) @(posedge clk); #1;
        stray_req++;
        seen = 1'b0;
        repeat (MAXLAT) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        n_checks++; if (seen !== 1'b0) $display("FAIL timeout_late_done: got rsp_valid %b expected 0", seen); else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_backpressure();
        test_reset_midwait();
        test_back_to_back();
`ifdef FDIV_SEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fdiv_seq.md
# fdiv_seq

Request sequencer placed directly upstream of the multi-cycle floating-point divider. Buffers divide requests from the issue logic in a small FIFO, dispatches one at a time only when the divider is idle, and pairs each divider completion with its request tag. Results return through a one-entry valid/ready output register.

## Interface
- DATAW, 32: operand and result width
- TAGW, 4: request tag width
- DEPTH, 4: request FIFO entries; power of 2, at least 2
- MAXLAT, 64: post-reset flush length and completion timeout in cycles; must exceed the divider's worst-case latency
- clk  in  1  clock; all state updates on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  FIFO not full
- req_a, req_b  in  DATAW  dividend, divisor
- req_op  in  2  passed through to the divider unchanged
- req_tag  in  TAGW  request identifier
- div_dispatch  out  1  one-cycle start pulse to the divider
- div_a, div_b  out  DATAW  divider operands, registered
- div_op  out  2  divider op, registered
- div_done  in  1  divider completion pulse
- div_q  in  DATAW  divider result, valid while div_done is high
- rsp_valid  out  1  result register full
- rsp_ready  in  1  consumer accepts the result
- rsp_q  out  DATAW  result
- rsp_tag  out  TAGW  tag of the completed request
- rsp_err  out  1  timeout marker; tied to 0 without the config macro

## Operation
- Reset values:
  - all outputs 0, except req_ready, which is 1;
  - FIFO empty;
  - state FLUSH with the flush counter at 0.
- FIFO:
  - push when req_valid and req_ready; req_ready = !full;
  - no full-bypass: a push is refused while the FIFO is full, even if a pop happens in the same cycle;
  - simultaneous push and pop on a non-full FIFO keeps the count unchanged;
  - pointers are log2(DEPTH)+1 bits wide and wrap naturally.
- FLUSH: the divider has no reset, so a divide started before reset may still be in flight.
  - Count MAXLAT cycles, ignoring div_done, then go to IDLE.
  - The FIFO keeps accepting requests during FLUSH.
- IDLE: dispatch when the FIFO is not empty and the slot is free, i.e. !rsp_valid, or rsp_valid && rsp_ready in the same cycle.
  - On dispatch, register the head entry's a/b/op onto div_a/div_b/div_op and pulse div_dispatch for exactly one cycle (the cycle after the dispatch decision).
  - Pop the head, latch its tag into cur_tag, clear the wait counter, go to WAIT.
  - div_done seen in IDLE is ignored.
- WAIT: increment the wait counter every cycle.
  - On div_done: rsp_q <= div_q, rsp_tag <= cur_tag, rsp_valid <= 1, rsp_err <= 0, go to IDLE.
- Response handshake:
  - rsp_valid && rsp_ready clears rsp_valid;
  - rsp_q and rsp_tag hold their values while rsp_valid && !rsp_ready.
- Ordering: at most one divide is outstanding, so results come back strictly in request order.
- Reset asserted mid-operation: all state clears immediately and FLUSH restarts. Queued requests are discarded; no response is produced for them.

## Timing
- Request accepted at edge T → earliest div_dispatch high in the cycle after edge T+1. The decision is made from registered FIFO state and the pulse is registered.
- div_done high in cycle C → rsp_valid high from cycle C+1.
- Divider trivial cases (NaN, zero, overflow, underflow) complete one cycle after dispatch. A full divide completes about 2*MANW+3 cycles after dispatch.
- Back-to-back: the next dispatch is decided in the cycle rsp_valid rises, provided rsp_ready is high or the slot empties.

## Configuration
- FDIV_SEQ_TIMEOUT_EN defined:
  - if WAIT reaches MAXLAT cycles without div_done, load rsp_q with the -NaN encoding (sign=1, exponent all ones, mantissa MSB=1), rsp_tag=cur_tag, rsp_err=1, rsp_valid=1;
  - then go to FLUSH, so a late div_done is absorbed and not paired with a later request.
- FDIV_SEQ_TIMEOUT_EN undefined:
  - WAIT lasts until div_done with no limit; rsp_err is constant 0;
  - the wait counter is not implemented.

## Test plan
- Reset release: rsp_valid=0, div_dispatch=0; no dispatch for MAXLAT cycles even with a request queued; a div_done pulse injected during FLUSH produces no response.
- Single request a=0x40400000, b=0x3F800000, tag=5, rsp_ready=1, divider model returns 0x40400000 after 48 cycles → exactly one div_dispatch pulse; rsp_q=0x40400000 and rsp_tag=5 one cycle after div_done.
- Fill DEPTH=4 entries with tags 1..4 plus a fifth request → req_ready=0 on the fifth; responses arrive in tag order 1,2,3,4; the fifth is accepted once the first pop frees a slot.
- Hold rsp_ready=0 with a result pending and the queue non-empty → no second dispatch; rsp_q/rsp_tag stable; after rsp_ready=1 the next dispatch is decided in that same cycle.
- Assert rsp_ready=1 and deassert then reassert rst_n mid-WAIT → outputs return to reset values at once; a stale div_done arriving inside FLUSH is dropped.
- With FDIV_SEQ_TIMEOUT_EN and a divider model that never completes → response 0xFFC00000 with rsp_err=1 after MAXLAT cycles; a late div_done yields no extra response.
